// File: rtl/traffic_light_pkg.sv
// Shared types and phase durations for the two-way traffic controller.
// Phase length lookup lives here so the FSM and timer agree on it.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    CLR_TO_MAIN = 2'd0,
    MAIN_GO     = 2'd1,
    CLR_TO_SIDE = 2'd2,
    SIDE_GO     = 2'd3
  } tl_state_e;

  localparam int MAIN_GREEN = 4;
  localparam int SIDE_GREEN = 3;
  localparam int CLEAR      = 1;

  function automatic int phase_len(
    tl_state_e s,
    int        main_len,
    int        side_len,
    int        clr_len
  );
    int len;
    len = 1;
    case (s)
      CLR_TO_MAIN: len = clr_len;
      MAIN_GO:     len = main_len;
      CLR_TO_SIDE: len = clr_len;
      SIDE_GO:     len = side_len;
      default:     len = 1;
    endcase
    return len;
  endfunction

  function automatic int max3(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Phase counter: counts cycles within a phase, flags the last one.
// Saturates at the limit so a stale count can never wrap.
module tl_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count;

  // >= rather than == so an out-of-range count still terminates
  assign done = (count >= limit);

  // count up until the terminal value, clear on phase change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (!done) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/traffic_light.sv
// Fixed-time main/side road signal: main go, clear, side go, clear.
// Outputs are registered alongside the state so they never glitch.
module traffic_light
  import traffic_light_pkg::*;
#(
  parameter int MAIN_GREEN_CYCLES = MAIN_GREEN,
  parameter int SIDE_GREEN_CYCLES = SIDE_GREEN,
  parameter int CLEAR_CYCLES      = CLEAR
) (
  input  logic clk,
  input  logic rst,
  output logic main_road,
  output logic side_road
);

  localparam int MAXD = max3(MAIN_GREEN_CYCLES,
                             SIDE_GREEN_CYCLES,
                             CLEAR_CYCLES);
  localparam int W = $clog2(MAXD) + 1;

  if (MAIN_GREEN_CYCLES < 1 ||
      SIDE_GREEN_CYCLES < 1 ||
      CLEAR_CYCLES < 1) begin : g_bad_param
    $fatal(1, "traffic_light: all durations must be >= 1");
  end

  tl_state_e    state;
  logic [W-1:0] limit;
  logic         tc;

  // terminal count for the phase currently being timed
  always_comb begin
    limit = W'(phase_len(state,
                         MAIN_GREEN_CYCLES,
                         SIDE_GREEN_CYCLES,
                         CLEAR_CYCLES) - 1);
  end

  tl_phase_timer #(
    .W (W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tc),
    .limit (limit),
    .done  (tc)
  );

  // phase sequencer with Moore outputs registered per next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= CLR_TO_MAIN;
      main_road <= 1'b0;
      side_road <= 1'b0;
    end else if (tc) begin
      case (state)
        CLR_TO_MAIN: begin
          state     <= MAIN_GO;
          main_road <= 1'b1;
          side_road <= 1'b0;
        end
        MAIN_GO: begin
          state     <= CLR_TO_SIDE;
          main_road <= 1'b0;
          side_road <= 1'b0;
        end
        CLR_TO_SIDE: begin
          state     <= SIDE_GO;
          main_road <= 1'b0;
          side_road <= 1'b1;
        end
        SIDE_GO: begin
          state     <= CLR_TO_MAIN;
          main_road <= 1'b0;
          side_road <= 1'b0;
        end
        default: begin
          state     <= CLR_TO_MAIN;
          main_road <= 1'b0;
          side_road <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light.sv
// Bench for traffic_light: default and overridden timing instances
// compared against a period/offset model of the signal plan.
`timescale 1ns/1ps
module tb_traffic_light;

  logic clk;
  logic rst;
  logic m1, s1;
  logic m2, s2;

  int k;
  int total;
  int passed;

  traffic_light u_dflt (
    .clk       (clk),
    .rst       (rst),
    .main_road (m1),
    .side_road (s1)
  );

  traffic_light #(
    .MAIN_GREEN_CYCLES (2),
    .SIDE_GREEN_CYCLES (5),
    .CLEAR_CYCLES      (2)
  ) u_alt (
    .clk       (clk),
    .rst       (rst),
    .main_road (m2),
    .side_road (s2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   edges;
    logic main_exp;
    logic side_exp;
  } vec_t;

  vec_t tbl[12];

  // signal plan as offsets within one period after release
  function automatic logic [1:0] model(int n, int mg, int sg, int cl);
    int p;
    int r;
    logic mo;
    logic so;
    p  = mg + sg + 2 * cl;
    r  = n % p;
    mo = (r >= cl) && (r < cl + mg);
    so = (r >= 2 * cl + mg);
    return {mo, so};
  endfunction

  task automatic check(string name, logic [1:0] got, logic [1:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %b expected %b (t=%0t k=%0d)",
               name, got, exp, $time, k);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, " dflt"}, {m1, s1}, model(k, 4, 3, 1));
    check({tag, " safe1"}, {1'b0, m1 & s1}, 2'b00);
    check({tag, " alt"}, {m2, s2}, model(k, 2, 5, 2));
    check({tag, " safe2"}, {1'b0, m2 & s2}, 2'b00);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) k++;
    @(negedge clk);
  endtask

  task automatic run_table(string tag);
    for (int i = 0; i < 12; i++) begin
      while (k < tbl[i].edges) cyc();
      check({tag, " tbl"}, {m1, s1}, {tbl[i].main_exp, tbl[i].side_exp});
      check_all(tag);
    end
  endtask

  initial begin
    int mcnt;
    int scnt;
    int mcnt2;
    int scnt2;
    bit found;

    tbl[0]  = '{0, 1'b0, 1'b0};
    tbl[1]  = '{1, 1'b1, 1'b0};
    tbl[2]  = '{2, 1'b1, 1'b0};
    tbl[3]  = '{3, 1'b1, 1'b0};
    tbl[4]  = '{4, 1'b1, 1'b0};
    tbl[5]  = '{5, 1'b0, 1'b0};
    tbl[6]  = '{6, 1'b0, 1'b1};
    tbl[7]  = '{7, 1'b0, 1'b1};
    tbl[8]  = '{8, 1'b0, 1'b1};
    tbl[9]  = '{9, 1'b0, 1'b0};
    tbl[10] = '{10, 1'b1, 1'b0};
    tbl[11] = '{14, 1'b0, 1'b0};

    total  = 0;
    passed = 0;
    k      = 0;
    rst    = 1'b0;

    #3;
    check("in_reset", {m1, s1}, 2'b00);
    check("in_reset alt", {m2, s2}, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    k   = 0;
    #1;
    run_table("first");

    for (int i = 0; i < 12; i++) begin
      cyc();
      check_all("run");
    end

    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (model(k, 4, 3, 1) == 2'b01 && s1) found = 1'b1;
      else cyc();
    end
    total++;
    if (found) passed++;
    else $display("FAIL find_side: got no SIDE_GO expected one");
    @(posedge clk);
    k++;
    #2;
    rst = 1'b0;
    k   = 0;
    #1;
    check("async_drop", {m1, s1}, 2'b00);
    check("async_drop alt", {m2, s2}, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    k   = 0;
    #1;
    run_table("restart");

    @(negedge clk);
    rst = 1'b0;
    k   = 0;
    #1;
    check_all("hold0");
    for (int i = 0; i < 12; i++) begin
      cyc();
      check_all("hold");
    end
    rst = 1'b1;
    k   = 0;
    #1;
    run_table("after_hold");

    for (int r = 0; r < 20; r++) begin
      int n;
      int h;
      n = $urandom_range(30, 1);
      for (int i = 0; i < n; i++) begin
        cyc();
        check_all("rand");
      end
      @(posedge clk);
      if (rst) k++;
      #($urandom_range(3, 1));
      rst = 1'b0;
      k   = 0;
      #1;
      check_all("rand_rst");
      h = $urandom_range(3, 0);
      for (int i = 0; i < h; i++) begin
        cyc();
        check_all("rand_hold");
      end
      @(negedge clk);
      rst = 1'b1;
      k   = 0;
      #1;
      check_all("rand_rel");
    end

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst   = 1'b1;
    k     = 0;
    mcnt  = 0;
    scnt  = 0;
    mcnt2 = 0;
    scnt2 = 0;
    for (int i = 0; i < 999; i++) begin
      cyc();
      mcnt += int'(m1);
      scnt += int'(s1);
      if (k <= 990) begin
        mcnt2 += int'(m2);
        scnt2 += int'(s2);
      end
    end
    total++;
    if (mcnt == (999 / 9) * 4) passed++;
    else $display("FAIL long_main: got %0d expected %0d", mcnt, 444);
    total++;
    if (scnt == (999 / 9) * 3) passed++;
    else $display("FAIL long_side: got %0d expected %0d", scnt, 333);
    total++;
    if (mcnt2 == (990 / 11) * 2) passed++;
    else $display("FAIL long_main alt: got %0d expected %0d", mcnt2, 180);
    total++;
    if (scnt2 == (990 / 11) * 5) passed++;
    else $display("FAIL long_side alt: got %0d expected %0d", scnt2, 450);
    check_all("long_end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
